// File: rtl/adder_result_fifo.sv
// Result stage behind the carry-select adder: rebuilds carry-out and signed
// overflow from operand/sum MSBs and buffers results in a show-ahead FIFO.
module adder_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_W-1:0]         i_a,
  input  logic [DATA_W-1:0]         i_b,
  input  logic [DATA_W-1:0]         i_sum,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_W-1:0]         o_sum,
  output logic                      o_carry,
  output logic                      o_ovf,
  output logic [$clog2(DEPTH):0]    o_level,
  output logic [CNT_W-1:0]          o_ovf_cnt,
  input  logic                      i_clr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Handshake: a transfer happens on a rising edge only when valid and ready
  // are both high on that side; ready never depends on the same-cycle valid.
  logic              wr_en;
  logic              rd_en;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] sum_mem   [DEPTH];
  logic              carry_mem [DEPTH];
  logic              ovf_mem   [DEPTH];

  logic a_msb;
  logic b_msb;
  logic s_msb;
  logic in_carry;
  logic in_ovf;

  assign a_msb    = i_a[DATA_W-1];
  assign b_msb    = i_b[DATA_W-1];
  assign s_msb    = i_sum[DATA_W-1];
  assign in_carry = (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  assign in_ovf   = (a_msb == b_msb) && (s_msb != a_msb);

  assign o_ready = (o_level < LW'(DEPTH));
  assign o_valid = (o_level != '0);
  assign wr_en   = i_valid && o_ready;
  assign rd_en   = o_valid && i_ready;

  // Storage is not reset, so the head is masked to zero while empty.
  assign o_sum   = o_valid ? sum_mem[rd_ptr]   : '0;
  assign o_carry = o_valid ? carry_mem[rd_ptr] : 1'b0;
  assign o_ovf   = o_valid ? ovf_mem[rd_ptr]   : 1'b0;

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      sum_mem[wr_ptr]   <= i_sum;
      carry_mem[wr_ptr] <= in_carry;
      ovf_mem[wr_ptr]   <= in_ovf;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   o_level <= o_level + LW'(1);
        2'b01:   o_level <= o_level - LW'(1);
        default: o_level <= o_level;
      endcase
    end
  end

  // Clear takes priority over a same-cycle overflow increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_ovf_cnt <= '0;
    end else if (wr_en && in_ovf && (o_ovf_cnt != '1)) begin
      o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
    end
  end

endmodule
